// File: rtl/spi_slave_param.sv
// SPI slave: 1-bit command, FRAME_W-bit frame capture, and a read path that
// waits for memory-side data, then serialises it out on MISO, MSB first.
module spi_slave_param #(
  parameter int DATA_W      = 8,
  parameter int TX_WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              MISO,
  output logic              frame_err,
  output logic              busy
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_MAX = (FRAME_W > TX_WAIT_MAX) ? FRAME_W : TX_WAIT_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_WAIT  = CNT_W'(TX_WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_TX    = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, READ_WAIT, READ_TX, DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] tx_sr;
  logic              rd_addr_done;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      MISO         <= 1'b0;
      frame_err    <= 1'b0;
      rd_addr_done <= 1'b0;
      cnt          <= '0;
      tx_sr        <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      MISO      <= 1'b0;
      // Deselect wins over everything, including the last frame bit.
      if (SS_n && state != IDLE) begin
        state <= IDLE;
        cnt   <= '0;
        if (state != DONE) frame_err <= 1'b1;
      end else begin
        case (state)
          IDLE: if (!SS_n) state <= CHK_CMD;
          CHK_CMD: begin
            cnt <= CNT_FRAME;
            if (!MOSI)             state <= WRITE;
            else if (rd_addr_done) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            rx_data <= {rx_data[FRAME_W-2:0], MOSI};
            cnt     <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              rx_valid <= 1'b1;
              cnt      <= '0;
              if (state == READ_DATA) state <= READ_WAIT;
              else                    state <= DONE;
              if (state == READ_ADD) rd_addr_done <= 1'b1;
            end
          end
          READ_WAIT: begin
            if (tx_valid) begin
              MISO  <= tx_data[DATA_W-1];
              tx_sr <= {tx_data[DATA_W-2:0], 1'b0};
              cnt   <= CNT_TX;
              state <= READ_TX;
            end else if (cnt == CNT_WAIT) begin
              // Timed out: address stays valid so the master can retry.
              frame_err <= 1'b1;
              cnt       <= '0;
              state     <= DONE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          READ_TX: begin
            if (cnt != '0) begin
              MISO  <= tx_sr[DATA_W-1];
              tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
              cnt   <= cnt - CNT_ONE;
            end else begin
              rd_addr_done <= 1'b0;
              state        <= DONE;
            end
          end
          DONE:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench: transaction tasks build the expected per-cycle output trace
// from the protocol rules; one process compares the DUT against that trace.
module tb_spi_slave_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       MISO;
  logic       frame_err;
  logic       busy;

  spi_slave_param #(.DATA_W(8), .TX_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .MISO(MISO), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       busy, rxv, miso, ferr, chk_rx, cap;
    logic [9:0] rx;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int rxv_cnt = 0, ferr_cnt = 0, miso_ones = 0;
  logic [9:0] rx_cap = '0;
  logic [7:0] miso_cap = '0;

  // Transaction-level model state
  bit         m_rad = 0;
  logic [9:0] m_rx = '0;
  bit         m_rx_ok = 1;
  int         g_abort = -1, g_rst = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("busy", 32'(busy), 32'(e.busy));
        chk("rx_valid", 32'(rx_valid), 32'(e.rxv));
        chk("MISO", 32'(MISO), 32'(e.miso));
        chk("frame_err", 32'(frame_err), 32'(e.ferr));
        if (e.chk_rx) chk("rx_data", 32'(rx_data), 32'(e.rx));
        if (e.cap) miso_cap = {miso_cap[6:0], MISO};
      end
      if (rx_valid === 1'b1) begin rxv_cnt++; rx_cap = rx_data; end
      if (frame_err === 1'b1) ferr_cnt++;
      if (MISO === 1'b1) miso_ones++;
    end
  end

  // One clock: drive inputs ahead of the edge, record what must follow it.
  task automatic cyc(input bit rst, input bit ss, input bit mosi, input bit txv,
                     input logic [7:0] txd, input bit e_busy, input bit e_rxv,
                     input bit e_miso, input bit e_ferr, input bit cap = 0);
    exp_t e;
    @(negedge clk);
    rst_n = rst; SS_n = ss; MOSI = mosi; tx_valid = txv; tx_data = txd;
    e.busy = e_busy; e.rxv = e_rxv; e.miso = e_miso; e.ferr = e_ferr;
    e.chk_rx = m_rx_ok; e.rx = m_rx; e.cap = cap;
    exp_q.push_back(e);
  endtask

  task automatic maybe_stop(input int k, input bit mosi, output bit stop);
    stop = 0;
    if (k == g_rst) begin
      m_rad = 0; m_rx = '0; m_rx_ok = 1;
      cyc(0, 0, mosi, 0, 8'h00, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
      stop = 1;
    end else if (k == g_abort) begin
      cyc(1, 1, mosi, 0, 8'h00, 0, 0, 0, 1);
      cyc(1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
      stop = 1;
    end
  endtask

  // k counts edges from the one that samples SS_n low.
  task automatic xact(input bit cmd, input logic [9:0] frm, input int tx_dly,
                      input logic [7:0] txd, input int abort_at = -1, input int rst_at = -1);
    bit stop, rd, fin;
    g_abort = abort_at; g_rst = rst_at; fin = 0;
    cyc(1, 0, 0, 0, 8'h00, 1, 0, 0, 0);
    maybe_stop(1, cmd, stop); if (stop) return;
    rd = cmd && m_rad;
    cyc(1, 0, cmd, 0, 8'h00, 1, 0, 0, 0);
    m_rx_ok = 0;
    for (int i = 0; i < 10; i++) begin
      maybe_stop(2 + i, frm[9-i], stop); if (stop) return;
      if (i == 9) begin m_rx = frm; m_rx_ok = 1; end
      cyc(1, 0, frm[9-i], 0, 8'h00, 1, (i == 9), 0, 0);
    end
    if (cmd && !rd) m_rad = 1;
    if (rd) begin
      for (int w = 0; w < 15 && !fin; w++) begin
        maybe_stop(12 + w, 0, stop); if (stop) return;
        if (w == tx_dly) begin
          cyc(1, 0, 0, 1, txd, 1, 0, txd[7], 0, 1);
          for (int b = 6; b >= 0; b--) begin
            maybe_stop(19 + w - b, 0, stop); if (stop) return;
            cyc(1, 0, 0, 0, 8'h00, 1, 0, txd[b], 0, 1);
          end
          maybe_stop(20 + w, 0, stop); if (stop) return;
          cyc(1, 0, 0, 0, 8'h00, 1, 0, 0, 0);
          m_rad = 0; fin = 1;
        end else begin
          cyc(1, 0, 0, 0, 8'h00, 1, 0, 0, (w == 14));
        end
      end
    end
    // DONE ignores MOSI and tx_valid; clean deselect raises no error.
    cyc(1, 0, 1, 1, 8'hFF, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 8'h00, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 8'h00, 0, 0, 0, 0);

    xact(0, 10'h0A5, -1, 8'h00);                    // write
    settle();
    chk("write_rx_lit", 32'(rx_cap), 32'h0A5);
    chk("write_rxv_cnt", 32'(rxv_cnt), 32'd1);

    xact(1, 10'h300, 3, 8'h3C);                     // no address yet: READ_ADD path
    settle();
    chk("noaddr_miso_quiet", 32'(miso_ones), 32'd0);
    chk("noaddr_rxv_cnt", 32'(rxv_cnt), 32'd2);

    xact(1, 10'h300, 3, 8'hC3);                     // read data
    settle();
    chk("read_miso_lit", 32'(miso_cap), 32'hC3);

    xact(1, 10'h203, -1, 8'h00);                    // read address
    settle();
    chk("addr_rx_lit", 32'(rx_cap), 32'h203);

    xact(1, 10'h3FF, -1, 8'h00);                    // timeout
    settle();
    chk("timeout_ferr_cnt", 32'(ferr_cnt), 32'd1);

    xact(1, 10'h3AA, 14, 8'h81);                    // retry, data on last wait cycle
    settle();
    chk("retry_miso_lit", 32'(miso_cap), 32'h81);

    xact(0, 10'h155, -1, 8'h00, 7);                 // abort after 5 frame bits
    settle();
    chk("abort_ferr_cnt", 32'(ferr_cnt), 32'd2);
    chk("abort_rxv_cnt", 32'(rxv_cnt), 32'd6);

    xact(1, 10'h2F0, -1, 8'h00, 11);                // abort on last frame bit
    xact(1, 10'h000, -1, 8'h00, 1);                 // abort in command phase
    xact(1, 10'h2F0, -1, 8'h00);                    // must still be an address frame
    xact(1, 10'h300, -1, 8'h00, 16);                // abort while waiting for tx_valid
    xact(1, 10'h300, 0, 8'hA5, 16);                 // abort mid-serialisation
    xact(1, 10'h300, 2, 8'h7E, -1, 18);             // reset mid-serialisation
    xact(0, 10'h3C3, -1, 8'h00);
    settle();
    chk("post_reset_write_lit", 32'(rx_cap), 32'h3C3);
    xact(1, 10'h001, -1, 8'h00);                    // reset cleared the address flag
    settle();

    chk("total_ferr", 32'(ferr_cnt), 32'd6);
    chk("total_rxv", 32'(rxv_cnt), 32'd12);
    chk("last_rx_lit", 32'(rx_cap), 32'h001);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
